// File: rtl/led_routine_gen_if.sv
// led_routine_gen_if: step strobe, mode selects and the
// LED/HEX output bus of the light-routine engine.
interface led_routine_gen_if #(
  parameter int GRN_W      = 8,
  parameter int RED_W      = 10,
  parameter int HEX_DIGITS = 4
);
  logic                    Enable;
  logic                    GrnMode;
  logic                    RedMode;
  logic [GRN_W-1:0]        LedGrn;
  logic [RED_W-1:0]        LedRed;
  logic [7*HEX_DIGITS-1:0] HexSeg;
  logic                    Done;

  modport master (
    output Enable,
    output GrnMode,
    output RedMode,
    input  LedGrn,
    input  LedRed,
    input  HexSeg,
    input  Done
  );

  modport slave (
    input  Enable,
    input  GrnMode,
    input  RedMode,
    output LedGrn,
    output LedRed,
    output HexSeg,
    output Done
  );
endinterface

// File: rtl/led_routine_gen.sv
// led_routine_gen: two LED bars (bounce/rotate), cascaded HEX
// counter and routine done pulse. Option: ROUTINE_PRESCALE_EN.
module led_routine_gen #(
  parameter int GRN_W      = 8,
  parameter int RED_W      = 10,
  parameter int BAR_LEN    = 4,
  parameter int HEX_DIGITS = 4,
  parameter int HEX_MOD    = 16,
  parameter int RTN_LEN    = 41
`ifdef ROUTINE_PRESCALE_EN
  ,
  parameter int PRESCALE_DIV = 4
`endif
) (
  input logic             Clock,
  input logic             Reset,
  led_routine_gen_if.slave bus
);

  localparam int GPW = $clog2(GRN_W);
  localparam int RPW = $clog2(RED_W);
  localparam int CW  = $clog2(RTN_LEN);

  localparam logic [GPW-1:0] G_N   = GPW'(GRN_W - BAR_LEN);
  localparam logic [GPW-1:0] G_TOP = GPW'(GRN_W - 1);
  localparam logic [RPW-1:0] R_N   = RPW'(RED_W - BAR_LEN);
  localparam logic [RPW-1:0] R_TOP = RPW'(RED_W - 1);
  localparam logic [CW-1:0]  C_LAST = CW'(RTN_LEN - 1);
  localparam logic [3:0]     D_MAX  = 4'(HEX_MOD - 1);

  localparam logic [GRN_W-1:0] G_ONES =
    {GRN_W{1'b1}} >> (GRN_W - BAR_LEN);
  localparam logic [RED_W-1:0] R_ONES =
    {RED_W{1'b1}} >> (RED_W - BAR_LEN);

  // Lit segment at position p, wrapping past the MSB.
  function automatic logic [GRN_W-1:0] grn_pat(
    input logic [GPW-1:0] p
  );
    logic [2*GRN_W-1:0] w;
    w = {{GRN_W{1'b0}}, G_ONES} << p;
    return w[GRN_W-1:0] | w[2*GRN_W-1:GRN_W];
  endfunction

  function automatic logic [RED_W-1:0] red_pat(
    input logic [RPW-1:0] p
  );
    logic [2*RED_W-1:0] w;
    w = {{RED_W{1'b0}}, R_ONES} << p;
    return w[RED_W-1:0] | w[2*RED_W-1:RED_W];
  endfunction

  // Active-low seven-segment shapes, bit order g..a.
  function automatic logic [6:0] seg_enc(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic                   step;

  logic [GPW-1:0]         gpos_q, gpos_d;
  logic                   gup_q, gup_d, g_eff;
  logic [RPW-1:0]         rpos_q, rpos_d;
  logic                   rup_q, rup_d, r_eff;

  logic [GRN_W-1:0]       grn_q;
  logic [RED_W-1:0]       red_q;

  logic [HEX_DIGITS-1:0][3:0] dig_q, dig_d;
  logic [HEX_DIGITS-1:0][6:0] seg_q, seg_d;
  logic                   carry;

  logic [CW-1:0]          cnt_q;
  logic                   done_q;

`ifdef ROUTINE_PRESCALE_EN
  localparam int PW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE_DIV - 1);

  logic [PW-1:0] pre_q;

  assign step = bus.Enable && (pre_q == P_LAST);

  // Prescaler counts enabled cycles; a step fires on its last count.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pre_q <= '0;
    end else if (bus.Enable) begin
      pre_q <= (pre_q == P_LAST) ? '0 : pre_q + PW'(1);
    end
  end
`else
  assign step = bus.Enable;
`endif

  // Green bar: rotate left, or bounce between 0 and G_N.
  always_comb begin
    gpos_d = gpos_q;
    gup_d  = gup_q;
    g_eff  = gup_q;
    if (bus.GrnMode) begin
      gpos_d = (gpos_q == G_TOP) ? '0 : gpos_q + GPW'(1);
    end else if (gpos_q > G_N) begin
      gpos_d = G_N;
      gup_d  = 1'b0;
    end else begin
      if (gpos_q == '0) begin
        g_eff = 1'b1;
      end else if (gpos_q == G_N) begin
        g_eff = 1'b0;
      end
      gpos_d = g_eff ? gpos_q + GPW'(1) : gpos_q - GPW'(1);
      if (gpos_d == G_N) begin
        gup_d = 1'b0;
      end else if (gpos_d == '0) begin
        gup_d = 1'b1;
      end else begin
        gup_d = g_eff;
      end
    end
  end

  // Red bar: rotate right, or bounce between 0 and R_N.
  always_comb begin
    rpos_d = rpos_q;
    rup_d  = rup_q;
    r_eff  = rup_q;
    if (bus.RedMode) begin
      rpos_d = (rpos_q == '0) ? R_TOP : rpos_q - RPW'(1);
    end else if (rpos_q > R_N) begin
      rpos_d = R_N;
      rup_d  = 1'b0;
    end else begin
      if (rpos_q == '0) begin
        r_eff = 1'b1;
      end else if (rpos_q == R_N) begin
        r_eff = 1'b0;
      end
      rpos_d = r_eff ? rpos_q + RPW'(1) : rpos_q - RPW'(1);
      if (rpos_d == R_N) begin
        rup_d = 1'b0;
      end else if (rpos_d == '0) begin
        rup_d = 1'b1;
      end else begin
        rup_d = r_eff;
      end
    end
  end

  // Cascaded digit counter and the segment image of its next value.
  always_comb begin
    carry = 1'b1;
    dig_d = dig_q;
    seg_d = '0;
    for (int k = 0; k < HEX_DIGITS; k++) begin
      if (carry) begin
        dig_d[k] = (dig_q[k] == D_MAX) ? 4'd0 : dig_q[k] + 4'd1;
      end
      carry    = carry && (dig_q[k] == D_MAX);
      seg_d[k] = seg_enc(dig_d[k]);
    end
  end

  // All state and registered outputs advance on a step only.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      gpos_q <= '0;
      gup_q  <= 1'b1;
      rpos_q <= R_N;
      rup_q  <= 1'b0;
      grn_q  <= G_ONES;
      red_q  <= red_pat(R_N);
      dig_q  <= '0;
      seg_q  <= {HEX_DIGITS{7'b1000000}};
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (step) begin
        gpos_q <= gpos_d;
        gup_q  <= gup_d;
        rpos_q <= rpos_d;
        rup_q  <= rup_d;
        grn_q  <= grn_pat(gpos_d);
        red_q  <= red_pat(rpos_d);
        dig_q  <= dig_d;
        seg_q  <= seg_d;
        if (cnt_q == C_LAST) begin
          cnt_q  <= '0;
          done_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  assign bus.LedGrn = grn_q;
  assign bus.LedRed = red_q;
  assign bus.HexSeg = seg_q;
  assign bus.Done   = done_q;

endmodule

// File: tb/tb_led_routine_gen.sv
// tb_led_routine_gen: directed stimulus with a stamped
// scoreboard queue checked by an independent monitor.
module tb_led_routine_gen;

  logic Clock;
  logic Reset;

  led_routine_gen_if #(.GRN_W(8), .RED_W(10), .HEX_DIGITS(4)) bus_a ();
  led_routine_gen_if #(.GRN_W(8), .RED_W(10), .HEX_DIGITS(2)) bus_b ();

  led_routine_gen dut_a (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus_a)
  );

  led_routine_gen #(
    .HEX_DIGITS (2),
    .HEX_MOD    (10)
  ) dut_b (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus_b)
  );

  localparam int ID_GRN  = 0;
  localparam int ID_RED  = 1;
  localparam int ID_HEXA = 2;
  localparam int ID_DONE = 3;
  localparam int ID_HEXB = 4;
  localparam int ID_POP  = 5;

  typedef struct {
    int unsigned stamp;
    int          id;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc;
  int          checks;
  int          errors;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  function automatic logic [31:0] hexa(
    input logic [6:0] d3, input logic [6:0] d2,
    input logic [6:0] d1, input logic [6:0] d0
  );
    return {4'h0, d3, d2, d1, d0};
  endfunction

  function automatic logic [31:0] hexb(
    input logic [6:0] d1, input logic [6:0] d0
  );
    return {18'h0, d1, d0};
  endfunction

  task automatic drive(input logic rst, input logic en,
                       input logic gm, input logic rm);
    @(negedge Clock);
    Reset         = rst;
    bus_a.Enable  = en;
    bus_b.Enable  = en;
    bus_a.GrnMode = gm;
    bus_b.GrnMode = gm;
    bus_a.RedMode = rm;
    bus_b.RedMode = rm;
  endtask

  task automatic push(input int id, input logic [31:0] v,
                      input string nm);
    exp_t e;
    e.stamp = cyc + 1;
    e.id    = id;
    e.val   = v;
    e.name  = nm;
    sb.push_back(e);
  endtask

  task automatic push_reset(input string nm);
    push(ID_GRN, 32'h0F, {nm, "_grn"});
    push(ID_RED, 32'h3C0, {nm, "_red"});
    push(ID_HEXA, hexa(7'h40, 7'h40, 7'h40, 7'h40), {nm, "_hexa"});
    push(ID_HEXB, hexb(7'h40, 7'h40), {nm, "_hexb"});
    push(ID_DONE, 32'h0, {nm, "_done"});
  endtask

  // Monitor: compare every entry stamped for the current cycle.
  always @(negedge Clock) begin
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].stamp <= cyc) begin
      e = sb.pop_front();
      act = '0;
      unique case (e.id)
        ID_GRN:  act = {24'h0, bus_a.LedGrn};
        ID_RED:  act = {22'h0, bus_a.LedRed};
        ID_HEXA: act = {4'h0, bus_a.HexSeg};
        ID_DONE: act = {31'h0, bus_a.Done};
        ID_HEXB: act = {18'h0, bus_b.HexSeg};
        default: act = $countones(bus_a.LedRed);
      endcase
      checks++;
      if (e.stamp != cyc) begin
        errors++;
        $display("FAIL %s stale entry at cycle %0d (stamp %0d)",
                 e.name, cyc, e.stamp);
      end else if (act !== e.val) begin
        errors++;
        $display("FAIL %s got %h want %h", e.name, act, e.val);
      end
    end
  end

  logic [31:0] g1 [10] = '{32'h1E, 32'h3C, 32'h78, 32'hF0, 32'h78,
                           32'h3C, 32'h1E, 32'h0F, 32'h1E, 32'h3C};
  logic [31:0] r1 [10] = '{32'h1E0, 32'h0F0, 32'h078, 32'h03C, 32'h01E,
                           32'h00F, 32'h01E, 32'h03C, 32'h078, 32'h0F0};
  logic [31:0] g2 [10] = '{32'h1E, 32'h3C, 32'h78, 32'hF0, 32'hE1,
                           32'hC3, 32'h87, 32'h0F, 32'h1E, 32'h3C};
  logic [31:0] r2 [10] = '{32'h1E0, 32'h0F0, 32'h078, 32'h03C, 32'h01E,
                           32'h00F, 32'h207, 32'h303, 32'h381, 32'h3C0};

  initial begin
    cyc           = 0;
    checks        = 0;
    errors        = 0;
    Reset         = 1'b1;
    bus_a.Enable  = 1'b0;
    bus_b.Enable  = 1'b0;
    bus_a.GrnMode = 1'b0;
    bus_b.GrnMode = 1'b0;
    bus_a.RedMode = 1'b0;
    bus_b.RedMode = 1'b0;

    // reset state, then bounce on both bars
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    push_reset("rst0");
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      push(ID_GRN, g1[k], $sformatf("bounce_grn%0d", k + 1));
      push(ID_RED, r1[k], $sformatf("bounce_red%0d", k + 1));
      push(ID_DONE, 32'h0, $sformatf("bounce_done%0d", k + 1));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    push(ID_HEXA, hexa(7'h40, 7'h40, 7'h40, 7'h08), "hexa_10");
    push(ID_HEXB, hexb(7'h79, 7'h40), "hexb_10");

    // reset with enable high, then rotate both bars
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    push_reset("rst1");
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b1);
      push(ID_GRN, g2[k], $sformatf("rot_grn%0d", k + 1));
      push(ID_RED, r2[k], $sformatf("rot_red%0d", k + 1));
      push(ID_POP, 32'd4, $sformatf("rot_pop%0d", k + 1));
    end

    // rotate to p=6 then switch to bounce: clamp, then move down
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    push_reset("rst2");
    for (int k = 0; k < 6; k++) drive(1'b0, 1'b1, 1'b1, 1'b0);
    push(ID_GRN, 32'hC3, "clamp_pre");
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    push(ID_GRN, 32'hF0, "clamp_hit");
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    push(ID_GRN, 32'h78, "clamp_next");

    // routine length: pulses on steps 41 and 82, gap after step 60
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    push_reset("rst3");
    for (int k = 1; k <= 82; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      push(ID_DONE, (k == 41 || k == 82) ? 32'h1 : 32'h0,
           $sformatf("done_step%0d", k));
      if (k == 41) begin
        push(ID_HEXA, hexa(7'h40, 7'h40, 7'h24, 7'h10), "hexa_41");
        push(ID_HEXB, hexb(7'h19, 7'h79), "hexb_41");
        push(ID_GRN, 32'h1E, "grn_41");
      end
      if (k == 60) begin
        for (int i = 0; i < 5; i++) begin
          drive(1'b0, 1'b0, 1'b0, 1'b0);
          push(ID_DONE, 32'h0, $sformatf("hold_done%0d", i));
          push(ID_HEXA, hexa(7'h40, 7'h40, 7'h30, 7'h46),
               $sformatf("hold_hexa%0d", i));
        end
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    push(ID_DONE, 32'h0, "done_after82");
    push(ID_HEXA, hexa(7'h40, 7'h40, 7'h12, 7'h24), "hexa_82");
    push(ID_HEXB, hexb(7'h00, 7'h24), "hexb_82");
    push(ID_GRN, 32'h3C, "grn_82");
    push(ID_RED, 32'hF0, "red_82");

    // reset mid-pass at step 20 restarts the routine
    for (int k = 0; k < 20; k++) drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    push_reset("rst_mid");
    for (int k = 1; k <= 42; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      push(ID_DONE, (k == 41) ? 32'h1 : 32'h0,
           $sformatf("mid_done%0d", k));
    end

    // decimal two-digit bank wraps 99 -> 00
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    push_reset("rst4");
    for (int k = 1; k <= 100; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      if (k == 99) push(ID_HEXB, hexb(7'h10, 7'h10), "hexb_99");
      if (k == 100) begin
        push(ID_HEXB, hexb(7'h40, 7'h40), "hexb_100");
        push(ID_HEXA, hexa(7'h40, 7'h40, 7'h02, 7'h19), "hexa_100");
      end
    end

    drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge Clock);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
